// File: rtl/dmem_responder_if.sv
// Load/store port between execute/memory stages and the data-memory responder.
// The core side (master) drives the request; the responder (slave) returns
// registered read data, stall and error.
interface dmem_responder_if;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [3:0]  mem_strb_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_rdata_o;
  logic        mem_stall_o;
  logic        mem_err_o;

  modport master (
    output mem_read_i, mem_write_i, mem_strb_i, mem_addr_i, mem_data_i,
    input  mem_rdata_o, mem_stall_o, mem_err_o
  );

  modport slave (
    input  mem_read_i, mem_write_i, mem_strb_i, mem_addr_i, mem_data_i,
    output mem_rdata_o, mem_stall_o, mem_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: services load/store requests from a word-addressed
// SRAM array built from four byte lanes, with WAIT_STATES stall cycles per
// access. Read data, stall and error are all registered.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,          // power of two, >= 2
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000, // aligned to DEPTH_WORDS*4
  parameter int          WAIT_STATES = 1              // 0..15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  dmem_responder_if.slave  bus
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic           req_rd, req_wr;
  logic [3:0]     req_strb;
  logic [31:0]    req_addr, req_data;

  // Access currently being performed at this edge (direct or latched).
  logic           acc_go, acc_rd, acc_wr;
  logic [3:0]     acc_strb;
  logic [31:0]    acc_addr, acc_data;
  logic [31:0]    offs;
  logic           in_rng;
  logic [AW-1:0]  idx;
  logic           wr_en;
  logic [3:0][7:0] rd_word;
  logic           req_vld;
  logic           unused_bits;

  assign req_vld = bus.mem_read_i | bus.mem_write_i;

  // Select the access source: live inputs with no wait states, else the
  // latched request on the final WAIT cycle.
  always_comb begin
    acc_go   = 1'b0;
    acc_rd   = 1'b0;
    acc_wr   = 1'b0;
    acc_strb = 4'h0;
    acc_addr = 32'h0;
    acc_data = 32'h0;
    if (WAIT_STATES == 0) begin
      acc_go   = req_vld;
      acc_rd   = bus.mem_read_i;
      acc_wr   = bus.mem_write_i;
      acc_strb = bus.mem_strb_i;
      acc_addr = bus.mem_addr_i;
      acc_data = bus.mem_data_i;
    end else begin
      acc_go   = (state == WAIT) && (cnt == 4'd1);
      acc_rd   = req_rd;
      acc_wr   = req_wr;
      acc_strb = req_strb;
      acc_addr = req_addr;
      acc_data = req_data;
    end
  end

  // Unsigned wrap makes addresses below BASE_ADDR land out of range too.
  assign offs        = acc_addr - BASE_ADDR;
  assign in_rng      = offs < SPAN;
  assign idx         = offs[AW+1:2];
  assign unused_bits = ^{offs[1:0], offs[31:AW+2]};
  // rst_ni gate keeps a zero-wait write from landing while reset is held.
  assign wr_en       = acc_go & acc_wr & in_rng & rst_ni;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];

    // One byte lane of the array; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
      if (wr_en && acc_strb[b]) lane_mem[idx] <= acc_data[8*b +: 8];
    end

    assign rd_word[b] = lane_mem[idx];
  end

  // Request FSM plus registered outputs; a read sees the pre-write word
  // because rd_word is sampled before the lane write commits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      req_rd          <= 1'b0;
      req_wr          <= 1'b0;
      req_strb        <= 4'h0;
      req_addr        <= 32'h0;
      req_data        <= 32'h0;
      bus.mem_rdata_o <= 32'h0;
      bus.mem_stall_o <= 1'b0;
      bus.mem_err_o   <= 1'b0;
    end else begin
      bus.mem_err_o <= 1'b0;
      if (acc_go) begin
        if (acc_rd) bus.mem_rdata_o <= in_rng ? rd_word : 32'h0;
        bus.mem_err_o <= ~in_rng;
      end
      if (WAIT_STATES != 0) begin
        case (state)
          IDLE: begin
            if (req_vld) begin
              req_rd          <= bus.mem_read_i;
              req_wr          <= bus.mem_write_i;
              req_strb        <= bus.mem_strb_i;
              req_addr        <= bus.mem_addr_i;
              req_data        <= bus.mem_data_i;
              cnt             <= WS;
              bus.mem_stall_o <= 1'b1;
              state           <= WAIT;
            end
          end
          WAIT: begin
            if (cnt > 4'd1) begin
              cnt <= cnt - 4'd1;
            end else begin
              cnt             <= 4'd0;
              bus.mem_stall_o <= 1'b0;
              state           <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the core's load/store port. It accepts the combinational request that the execute stage drives each cycle (read/write, byte strobe, word-aligned address, write data) and services it from an internal word-addressed SRAM array. It inserts a configurable number of wait states, requesting a pipeline stall while busy, and returns registered read data to the memory stage.

## Interface
- `DEPTH_WORDS`, default 1024 — number of 32-bit words in the array; power of two.
- `BASE_ADDR`, default 32'h0000_0000 — byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `WAIT_STATES`, default 1 — stall cycles per access; legal range 0..15.
- `clk_i` input 1 — single clock; all state updates on rising edge.
- `rst_ni` input 1 — reset, asynchronous, active-low.
- `mem_read_i` input 1 — read request (already squash/valid-qualified by execute).
- `mem_write_i` input 1 — write request (already qualified).
- `mem_strb_i` input 4 — byte-lane write enables; bit k covers data[8k+7:8k].
- `mem_addr_i` input 32 — byte address; bits [1:0] ignored.
- `mem_data_i` input 32 — write data, already lane-aligned.
- `mem_rdata_o` output 32 — registered read word to memory stage.
- `mem_stall_o` output 1 — registered stall request to hazard/stage control.
- `mem_err_o` output 1 — registered one-cycle flag: access fell outside the array.

## Operation
- States: IDLE, WAIT. Internal: 4-bit `cnt`; latched `req_rd`, `req_wr`, `req_strb`, `req_addr`, `req_data`.
- Request valid = `mem_read_i | mem_write_i`, sampled only in IDLE. Inputs are ignored in WAIT.
- Index = `(mem_addr_i - BASE_ADDR) >> 2`. In range iff `mem_addr_i - BASE_ADDR < DEPTH_WORDS*4` (unsigned, 32-bit wrap).
- Access (performed at one edge):
  - Write sets the strobed byte lanes only; a write with `strb=0` changes nothing.
  - Read loads the full word into `mem_rdata_o` regardless of strobe.
  - Read and write together: `mem_rdata_o` gets the pre-write word, then the write commits.
- Out-of-range access: no array change; `mem_rdata_o` <= 0 if read; `mem_err_o` = 1 for the one cycle in which `mem_rdata_o` is presented.
- `WAIT_STATES == 0`:
  - Always IDLE; a valid request is accessed at the edge ending its cycle.
  - `mem_stall_o` stays 0.
- `WAIT_STATES > 0`:
  - IDLE + valid request: latch the request, set `cnt` <= `WAIT_STATES`, `mem_stall_o` <= 1, go to WAIT.
  - WAIT with `cnt > 1`: decrement `cnt`.
  - WAIT with `cnt == 1`: perform the latched access, `mem_stall_o` <= 0, go to IDLE.
- `mem_rdata_o` holds its value when no read completes.
- `mem_err_o` clears on the next edge unless another erroring access completes.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `cnt` 0, `mem_rdata_o` 0, `mem_stall_o` 0, `mem_err_o` 0. Array contents are not reset.
- Request in cycle N, W = `WAIT_STATES`:
  - `mem_stall_o` is high in cycles N+1..N+W.
  - Read data and `mem_err_o` are valid in cycle N+W+1, the first cycle after the stall drops.
  - W=0: data is valid in N+1.
- Write is visible to a read accepted at cycle N+W+1 or later.
- Back-to-back: a request presented in cycle N+W+1 (stall low) is accepted; throughput is one access per W+1 cycles, or one per cycle when W=0.
- Reset asserted mid-WAIT: the pending access is dropped (no array write) and stall deasserts immediately.
- `mem_stall_o` never depends combinationally on inputs.

## Test plan
- Reset, W=1: assert `rst_ni`=0 mid-cycle -> all outputs 0 without a clock edge. Release; idle inputs -> stall stays 0.
- W=0: write 32'hDEADBEEF, strb 4'hF, to 0x10; read 0x10 the next cycle -> `mem_rdata_o` = 32'hDEADBEEF in the cycle after the read; stall never 1.
- W=0 byte strobe: word 0x20 = 32'h11223344; write 32'hAA00_0000, strb 4'b1000 -> a read of 0x20 returns 32'hAA223344.
- W=3: read 0x10 in cycle N -> stall high in N+1..N+3; data in N+4. Inputs changed to another address during N+1..N+3 are ignored.
- Out-of-range: DEPTH_WORDS=1024, read 0x1000 -> `mem_rdata_o` = 0 and `mem_err_o` = 1 for exactly one cycle. Write 32'h1 to 0x1000 -> word 0 unchanged.
- W=2: write 32'h5 to 0x40; assert reset during the first WAIT cycle -> after release, a read of 0x40 returns the old value, not 32'h5.
